// File: rtl/seq_div_unit.sv
// seq_div_unit: iterative restoring divider for the DIV/DIVU instructions.
// One quotient bit is retired per clock. Operands are reduced to magnitudes
// on acceptance, divided unsigned, and the signs are restored at the end.
// The quotient goes to LO and the remainder to HI through a
// START/BUSY/DONE handshake with the pipeline stall logic.
module seq_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             SIGNED_OP,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV_ZERO,
    output logic [WIDTH-1:0] QUO,
    output logic [WIDTH-1:0] REM
);

    // The step counter must be able to hold WIDTH itself.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    // Partial remainder, and the dividend register that fills with
    // quotient bits from the right as it shifts out to the left.
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] quo_shift;
    logic [WIDTH-1:0] dsr_mag;
    logic [WIDTH-1:0] raw_dividend;
    logic [CW-1:0]    cnt;
    logic             quo_neg;
    logic             rem_neg;
    logic             zero_div;

    // Operand preparation on the accept edge.
    logic             dvd_neg;
    logic             dsr_neg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dsr_abs;

    // One restoring step and the final sign correction.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo_fixed;
    logic [WIDTH-1:0] rem_fixed;

    // Magnitudes of the incoming operands; the most negative value simply
    // maps onto itself, read as an unsigned WIDTH-bit quantity.
    always_comb begin
        dvd_neg = SIGNED_OP & DIVIDEND[WIDTH-1];
        dsr_neg = SIGNED_OP & DIVISOR[WIDTH-1];
        dvd_abs = dvd_neg ? (~DIVIDEND + WIDTH'(1)) : DIVIDEND;
        dsr_abs = dsr_neg ? (~DIVISOR + WIDTH'(1)) : DIVISOR;
    end

    // Trial subtraction. Since the partial remainder is always below the
    // divisor, WIDTH+1 bits are enough for the sign of the trial to be exact.
    always_comb begin
        shifted   = {part_rem, quo_shift[WIDTH-1]};
        trial     = shifted - {1'b0, dsr_mag};
        quo_fixed = quo_neg ? (~quo_shift + WIDTH'(1)) : quo_shift;
        rem_fixed = rem_neg ? (~part_rem + WIDTH'(1)) : part_rem;
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept, WIDTH steps, sign fix, one-cycle result.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (START) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    next_state = FIN;
                end
            end
            FIN: begin
                next_state = OUT;
            end
            OUT: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        case (state)
            RUN: begin
                BUSY = 1'b1;
            end
            FIN: begin
                BUSY = 1'b1;
            end
            OUT: begin
                BUSY = 1'b1;
                DONE = 1'b1;
            end
            default: begin
                BUSY = 1'b0;
                DONE = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture, restoring steps, and result registers that
    // hold until the FIN edge of the following operation.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            part_rem     <= '0;
            quo_shift    <= '0;
            dsr_mag      <= '0;
            raw_dividend <= '0;
            cnt          <= '0;
            quo_neg      <= 1'b0;
            rem_neg      <= 1'b0;
            zero_div     <= 1'b0;
            QUO          <= '0;
            REM          <= '0;
            DIV_ZERO     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        part_rem     <= '0;
                        quo_shift    <= dvd_abs;
                        dsr_mag      <= dsr_abs;
                        raw_dividend <= DIVIDEND;
                        cnt          <= CNT_INIT;
                        quo_neg      <= dvd_neg ^ dsr_neg;
                        rem_neg      <= dvd_neg;
                        zero_div     <= (DIVISOR == '0);
                    end
                end
                RUN: begin
                    if (trial[WIDTH]) begin
                        part_rem <= shifted[WIDTH-1:0];
                    end else begin
                        part_rem <= trial[WIDTH-1:0];
                    end
                    quo_shift <= {quo_shift[WIDTH-2:0], ~trial[WIDTH]};
                    cnt       <= cnt - CNT_LAST;
                end
                FIN: begin
                    if (zero_div) begin
                        QUO <= '1;
                        REM <= raw_dividend;
                    end else begin
                        QUO <= quo_fixed;
                        REM <= rem_fixed;
                    end
                    DIV_ZERO <= zero_div;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
